rename_regfile: RTL
===================

Name: rename_regfile

Overview:
- Architectural register file with per-register rename status for the out-of-order core.
- Each entry packs {valid, tail, data}, and two combinational read ports feed the decode stage.
- Dispatch allocates a destination: it clears valid and records the producer tag (tail).
- The result broadcast (CDB) writes data back and sets valid only when the broadcast tag matches the entry's current tail. This makes the block the writer/producer end of the 40-bit source-operand interface that decode consumes.

Parameters:
- XLEN, 32, data width.
- TAG_W, 7, producer tag (tail) width.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra1  in  5  read address, port 1.
- ra2  in  5  read address, port 2.
- rd1  out  40  port-1 entry {valid[39], tail[38:32], data[31:0]}.
- rd2  out  40  port-2 entry, same format.
- alloc_en  in  1  dispatch is renaming destination alloc_rd this cycle.
- alloc_rd  in  5  destination register.
- alloc_tag  in  7  tag assigned to the producing instruction.
- wb_en  in  1  CDB result valid.
- wb_rd  in  5  CDB destination register.
- wb_tag  in  7  CDB producer tag.
- wb_data  in  32  CDB result.
- flush  in  1  mispredict recovery.
- pending_cnt  out  6  number of entries with valid=0.

Behaviour:
- Reset (async, rst_n=0):
  - Every entry becomes {1, 0, 0}.
  - pending_cnt = 0.
  - rd1/rd2 immediately read {1, 0, 0}.
- Register x0:
  - Always reads {1, 7'd0, 32'd0}.
  - alloc and wb targeting x0 are ignored and do not affect pending_cnt.
- Reads are combinational with a writeback bypass:
  - If wb_en, wb_rd == ra, ra != 0, the entry has valid=0 and entry.tail == wb_tag, the read returns {1, wb_tag, wb_data}.
  - Otherwise the read returns the stored entry.
  - Same-cycle alloc is NOT bypassed to reads. Reads show the pre-rename state, so an instruction such as "add x5,x5,x1" sees the old x5.
- Writeback on the clock edge:
  - Fires if wb_en, wb_rd != 0, entry.valid == 0 and entry.tail == wb_tag.
  - Effect: data <= wb_data, valid <= 1; tail is kept.
  - Tag mismatch (stale producer, register already renamed again) or an already-valid entry: no state change.
- Allocation on the clock edge:
  - Fires if alloc_en and alloc_rd != 0.
  - Effect: valid <= 0, tail <= alloc_tag; data is kept.
  - Re-allocating an entry that is already pending overwrites the tail. pending_cnt is unchanged in that case.
- Simultaneous alloc and wb to the same register: alloc wins. The final entry is {0, alloc_tag, wb_data if the wb tag matched, else old data}.
- Simultaneous alloc and wb to different registers: both take effect.
- Flush:
  - On the clock edge, all entries set valid <= 1; data and tail are kept.
  - Any same-cycle alloc is ignored; a same-cycle matching wb still writes data.
  - pending_cnt <= 0.
  - flush has priority over alloc.
- pending_cnt:
  - Update rule is count + (alloc makes a valid entry pending) − (wb completes a pending entry), evaluated per the rules above.
  - Range 0..31; it can never wrap because x0 is excluded.
  - Registered; it equals the popcount of ~valid at every cycle.
- No internal stall: dispatch gates alloc_en externally.

Decomposition:
- Package rf_pkg holds:
  - XLEN, TAG_W, NREG, ENTRY_W = 1 + TAG_W + XLEN.
  - Field offsets VALID_BIT = 39, TAIL_HI = 38, TAIL_LO = 32.
  - The entry pack/unpack function.
- Sub-module rf_entry, one per register x1..x31:
  - Holds the valid/tail/data flops.
  - Applies the alloc/wb/flush priority for that register.
  - Outputs its packed entry and a pending flag.

Test Plan:
- Reset: drive rst_n=0 mid-operation with x3 pending -> rd1 (ra1=3) becomes 0x80_0000_0000 asynchronously and pending_cnt=0.
- Rename then complete:
  - alloc x5 with tag 0x12 -> next cycle rd1(ra1=5) = {0, 0x12, old data}, pending_cnt=1.
  - wb x5, tag 0x12, data 0xDEADBEEF -> the same cycle reads {1, 0x12, 0xDEADBEEF} via bypass; the following cycle the stored entry equals that value and pending_cnt=0.
- Stale writeback:
  - alloc x7 with tag 3, then alloc x7 with tag 9.
  - wb x7 tag 3 data 0x1111 -> x7 stays {0, 9, old}.
  - wb tag 9 data 0x2222 -> {1, 9, 0x2222}.
- Same-cycle collision: x8 pending with tag 4; alloc x8 tag 6 together with wb x8 tag 4 data 0xAA -> entry {0, 6, 0xAA}, pending_cnt unchanged.
- x0 and flush:
  - alloc x0 and wb x0 -> rd reads 0x80_0000_0000 and the count is unchanged.
  - With x1, x2, x3 pending, assert flush together with alloc x4 -> all four read valid=1, x4 is not renamed, pending_cnt=0.
- Dual-port read: ra1=ra2=10 during a matching wb to x10 -> rd1 == rd2 == {1, tag, wb_data}.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing, entry layout and helpers for the rename register file.
package rf_pkg;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 7;
  localparam int NREG      = 32;
  localparam int IDX_W     = $clog2(NREG);
  localparam int CNT_W     = $clog2(NREG) + 1;
  localparam int ENTRY_W   = 1 + TAG_W + XLEN;
  localparam int VALID_BIT = ENTRY_W - 1;
  localparam int TAIL_HI   = ENTRY_W - 2;
  localparam int TAIL_LO   = XLEN;

  typedef logic [ENTRY_W-1:0] entry_bits_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tail;
    logic [XLEN-1:0]  data;
  } rf_entry_t;

  localparam entry_bits_t RESET_ENTRY = {1'b1, {(ENTRY_W-1){1'b0}}};

  function automatic entry_bits_t pack_entry(input rf_entry_t e);
    return {e.valid, e.tail, e.data};
  endfunction

  function automatic rf_entry_t unpack_entry(input entry_bits_t b);
    rf_entry_t e;
    e.valid = b[VALID_BIT];
    e.tail  = b[TAIL_HI:TAIL_LO];
    e.data  = b[XLEN-1:0];
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rename_regfile_if.sv
// Decode read ports, dispatch rename, CDB writeback and flush bundled as one bus.
interface rename_regfile_if;
  import rf_pkg::*;

  logic [IDX_W-1:0] ra1;
  logic [IDX_W-1:0] ra2;
  entry_bits_t      rd1;
  entry_bits_t      rd2;
  logic             alloc_en;
  logic [IDX_W-1:0] alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_en;
  logic [IDX_W-1:0] wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output ra1, ra2, alloc_en, alloc_rd, alloc_tag,
    output wb_en, wb_rd, wb_tag, wb_data, flush,
    input  rd1, rd2, pending_cnt
  );

  modport slave (
    input  ra1, ra2, alloc_en, alloc_rd, alloc_tag,
    input  wb_en, wb_rd, wb_tag, wb_data, flush,
    output rd1, rd2, pending_cnt
  );
endinterface

// File: rtl/rf_entry.sv
// One architectural register: valid/tail/data state with flush > alloc > wb priority.
module rf_entry
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_sel,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_sel,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output entry_bits_t      entry,
  output logic             pending,
  output logic             pending_next
);
  logic             valid_reg, valid_next;
  logic [TAG_W-1:0] tail_reg, tail_next;
  logic [XLEN-1:0]  data_reg, data_next;
  logic             wb_hit, alloc_hit;

  always_comb begin
    wb_hit     = wb_sel && !valid_reg && (tail_reg == wb_tag);
    alloc_hit  = alloc_sel && !flush;
    valid_next = valid_reg;
    tail_next  = tail_reg;
    data_next  = data_reg;
    // A matching writeback still lands its data even when alloc or flush wins the valid bit.
    if (wb_hit) begin
      data_next  = wb_data;
      valid_next = 1'b1;
    end
    if (flush) begin
      valid_next = 1'b1;
    end else if (alloc_hit) begin
      valid_next = 1'b0;
      tail_next  = alloc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b1;
      tail_reg  <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      tail_reg  <= tail_next;
      data_reg  <= data_next;
    end
  end

  assign entry        = pack_entry('{valid: valid_reg, tail: tail_reg, data: data_reg});
  assign pending      = ~valid_reg;
  assign pending_next = ~valid_next;
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename status, two bypassed read ports and a pending counter.
module rename_regfile
  import rf_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  rename_regfile_if.slave rf
);
  entry_bits_t      entries [NREG];
  logic [NREG-1:0]  pending_vec;
  logic [NREG-1:0]  pending_next_vec;
  logic [IDX_W-1:0] ra_arr [2];
  entry_bits_t      rd_arr [2];
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] rise, fall;

  // x0 is hardwired and never pending.
  assign entries[0]          = RESET_ENTRY;
  assign pending_vec[0]      = 1'b0;
  assign pending_next_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_entry
      rf_entry u_entry (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_sel    (rf.alloc_en && (rf.alloc_rd == IDX_W'(gi))),
        .alloc_tag    (rf.alloc_tag),
        .wb_sel       (rf.wb_en && (rf.wb_rd == IDX_W'(gi))),
        .wb_tag       (rf.wb_tag),
        .wb_data      (rf.wb_data),
        .flush        (rf.flush),
        .entry        (entries[gi]),
        .pending      (pending_vec[gi]),
        .pending_next (pending_next_vec[gi])
      );
    end
  endgenerate

  assign ra_arr[0] = rf.ra1;
  assign ra_arr[1] = rf.ra2;

  // Reads forward a completing writeback but never a same-cycle rename.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rf_entry_t e;
        e          = unpack_entry(entries[ra_arr[gi]]);
        rd_arr[gi] = entries[ra_arr[gi]];
        if (rf.wb_en && (rf.wb_rd == ra_arr[gi]) && (ra_arr[gi] != '0) &&
            !e.valid && (e.tail == rf.wb_tag)) begin
          rd_arr[gi] = pack_entry('{valid: 1'b1, tail: rf.wb_tag, data: rf.wb_data});
        end
      end
    end
  endgenerate

  assign rf.rd1 = rd_arr[0];
  assign rf.rd2 = rd_arr[1];

  always_comb begin
    rise     = popcount(pending_next_vec & ~pending_vec);
    fall     = popcount(pending_vec & ~pending_next_vec);
    cnt_next = rf.flush ? '0 : (cnt_reg + rise - fall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign rf.pending_cnt = cnt_reg;
endmodule
